// File: rtl/traffic_pkg.sv
// Shared types for the two-road intersection controller: phase encoding and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALL_RED1 = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALL_RED2 = 3'd5,
    NIGHT    = 3'd6
  } state_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 0..99 binary to two-digit BCD {tens, ones}.
module bin2bcd_2d (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = '0;
    for (int i = 1; i < 10; i++) begin
      if (bin_i >= 7'(10 * i)) tens = 4'(i);
    end
    ones = 4'(bin_i - 7'(tens) * 7'd10);
  end

  assign bcd_o = {tens, ones};

endmodule

// File: rtl/traffic_light_ctrl_2way.sv
// Main/side intersection controller with pedestrian green-cut, night flash and BCD countdowns.
// All outputs registered from next-state values: they move one clock after the tick/edge; no backpressure.
module traffic_light_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int T_MAIN_GREEN = 30,
  parameter int T_SIDE_GREEN = 20,
  parameter int T_YELLOW     = 3,
  parameter int T_ALLRED     = 2,
  parameter int T_PED_CUT    = 5,
  parameter int CNT_W        = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tick_1s,
  input  logic        ped_req,
  input  logic        night_mode,
  output logic [2:0]  light_main,
  output logic [2:0]  light_side,
  output logic [15:0] light_t,
  output logic        ped_walk,
  output logic        ped_pending,
  output logic [2:0]  phase
);

  localparam logic [CNT_W-1:0] C_MG  = CNT_W'(T_MAIN_GREEN);
  localparam logic [CNT_W-1:0] C_SG  = CNT_W'(T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] C_Y   = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] C_AR  = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] C_PC  = CNT_W'(T_PED_CUT);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [7:0]       AR_BCD = 8'((T_ALLRED / 10) * 16 + (T_ALLRED % 10));

  logic ped_s1_q, ped_s2_q, ped_prev_q, night_s1_q, night_s2_q;
  logic ped_rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  logic             pend_q, pend_d;

  logic [2:0]       main_d, side_d;
  logic [CNT_W-1:0] main_bin, side_bin;
  logic [7:0]       main_bcd, side_bcd;
  logic [2:0]       light_main_q, light_side_q;
  logic [15:0]      light_t_q;
  logic             ped_walk_q;

  function automatic state_e next_of(input state_e s);
    case (s)
      MAIN_G:   return MAIN_Y;
      MAIN_Y:   return ALL_RED1;
      ALL_RED1: return SIDE_G;
      SIDE_G:   return SIDE_Y;
      SIDE_Y:   return ALL_RED2;
      default:  return MAIN_G;
    endcase
  endfunction

  // A latched request shortens the main green already at entry.
  function automatic logic [CNT_W-1:0] dur_of(input state_e s, input logic pend);
    case (s)
      MAIN_G:         return pend ? C_PC : C_MG;
      MAIN_Y, SIDE_Y: return C_Y;
      SIDE_G:         return C_SG;
      default:        return C_AR;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_s1_q   <= 1'b0;
      ped_s2_q   <= 1'b0;
      ped_prev_q <= 1'b0;
      night_s1_q <= 1'b0;
      night_s2_q <= 1'b0;
    end else begin
      ped_s1_q   <= ped_req;
      ped_s2_q   <= ped_s1_q;
      ped_prev_q <= ped_s2_q;
      night_s1_q <= night_mode;
      night_s2_q <= night_s1_q;
    end
  end

  assign ped_rise = ped_s2_q & ~ped_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    pend_d  = pend_q;
    if (night_s2_q) begin
      if (state_q != NIGHT) begin
        state_d = NIGHT;
        flash_d = 1'b1;
      end else if (tick_1s) begin
        flash_d = ~flash_q;
      end
    end else if (state_q == NIGHT) begin
      state_d = ALL_RED2;
      cnt_d   = C_AR;
      flash_d = 1'b0;
    end else begin
      if (ped_rise) pend_d = 1'b1;
      if (tick_1s && cnt_q == C_ONE) begin
        state_d = next_of(state_q);
        cnt_d   = dur_of(state_d, pend_d);
        if (state_d == SIDE_G) pend_d = 1'b0;
      end else if (state_q == MAIN_G && pend_d && cnt_q > C_PC) begin
        cnt_d = C_PC;
      end else if (tick_1s) begin
        cnt_d = cnt_q - C_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ALL_RED2;
      cnt_q   <= C_AR;
      flash_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      pend_q  <= pend_d;
    end
  end

  // Red road shows time until its own green, except in the all-red right after its yellow.
  always_comb begin
    main_d   = LT_RED;
    side_d   = LT_RED;
    main_bin = '0;
    side_bin = '0;
    case (state_d)
      MAIN_G: begin
        main_d   = LT_GRN;
        main_bin = cnt_d;
        side_bin = cnt_d + C_Y + C_AR;
      end
      MAIN_Y: begin
        main_d   = LT_YEL;
        main_bin = cnt_d;
        side_bin = cnt_d + C_AR;
      end
      ALL_RED1: side_bin = cnt_d;
      SIDE_G: begin
        side_d   = LT_GRN;
        side_bin = cnt_d;
        main_bin = cnt_d + C_Y + C_AR;
      end
      SIDE_Y: begin
        side_d   = LT_YEL;
        side_bin = cnt_d;
        main_bin = cnt_d + C_AR;
      end
      ALL_RED2: main_bin = cnt_d;
      default: begin
        main_d = flash_d ? LT_YEL : LT_OFF;
        side_d = flash_d ? LT_YEL : LT_OFF;
      end
    endcase
  end

  bin2bcd_2d u_bcd_main (.bin_i(7'(main_bin)), .bcd_o(main_bcd));
  bin2bcd_2d u_bcd_side (.bin_i(7'(side_bin)), .bcd_o(side_bcd));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      light_main_q <= LT_RED;
      light_side_q <= LT_RED;
      light_t_q    <= {AR_BCD, 8'h00};
      ped_walk_q   <= 1'b0;
    end else begin
      light_main_q <= main_d;
      light_side_q <= side_d;
      light_t_q    <= {main_bcd, side_bcd};
      ped_walk_q   <= (state_d == SIDE_G);
    end
  end

  assign light_main  = light_main_q;
  assign light_side  = light_side_q;
  assign light_t     = light_t_q;
  assign ped_walk    = ped_walk_q;
  assign ped_pending = pend_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_2way.sv
// Bench for traffic_light_ctrl_2way: phase-table model checked every cycle plus literal checkpoints.
module tb_traffic_light_ctrl_2way;

  localparam int TMG = 30, TSG = 20, TY = 3, TA = 2, TPC = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        tick_1s = 1'b0;
  logic        ped_req = 1'b0;
  logic        night_mode = 1'b0;
  logic [2:0]  light_main, light_side, phase;
  logic [15:0] light_t;
  logic        ped_walk, ped_pending;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  traffic_light_ctrl_2way #(
    .T_MAIN_GREEN(TMG), .T_SIDE_GREEN(TSG), .T_YELLOW(TY),
    .T_ALLRED(TA), .T_PED_CUT(TPC), .CNT_W(7)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_1s(tick_1s),
    .ped_req(ped_req), .night_mode(night_mode),
    .light_main(light_main), .light_side(light_side), .light_t(light_t),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
  );

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase index 0..5 walks the table MG,Y,AR,SG,Y,AR; rem = ticks left in phase.
  function automatic int dur_of(input int p);
    case (p)
      0: return TMG;
      3: return TSG;
      1, 4: return TY;
      default: return TA;
    endcase
  endfunction

  function automatic int ttg(input int p, input int rem, input int green);
    int t = rem;
    int q = (p + 1) % 6;
    while (q != green) begin
      t += dur_of(q);
      q = (q + 1) % 6;
    end
    return t;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  int m_ph = 5, m_rem = TA;
  bit m_pend = 0, m_night = 0, m_flash = 0;
  bit pq[3], nq[3];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    bit rise, nt;
    if (!sys_rst_n) begin
      m_ph = 5; m_rem = TA; m_pend = 0; m_night = 0; m_flash = 0;
      for (int i = 0; i < 3; i++) begin pq[i] = 0; nq[i] = 0; end
    end else begin
      rise = pq[1] && !pq[2];
      nt   = nq[1];
      if (nt) begin
        if (!m_night) begin m_night = 1; m_flash = 1; end
        else if (tick_1s) m_flash = !m_flash;
      end else if (m_night) begin
        m_night = 0; m_flash = 0; m_ph = 5; m_rem = TA;
      end else begin
        if (rise) m_pend = 1;
        if (tick_1s && m_rem == 1) begin
          m_ph  = (m_ph + 1) % 6;
          m_rem = (m_ph == 0 && m_pend) ? TPC : dur_of(m_ph);
          if (m_ph == 3) m_pend = 0;
        end else if (m_ph == 0 && m_pend && m_rem > TPC) begin
          m_rem = TPC;
        end else if (tick_1s) begin
          m_rem = m_rem - 1;
        end
      end
      pq[2] = pq[1]; pq[1] = pq[0]; pq[0] = ped_req;
      nq[2] = nq[1]; nq[1] = nq[0]; nq[0] = night_mode;
    end
  end

  always @(negedge sys_clk) begin
    logic [2:0] em, es, ep;
    logic [15:0] et;
    logic ew;
    int mv, sv;
    if (cmp_en) begin
      if (m_night) begin
        em = {1'b0, m_flash, 1'b0}; es = em; et = 16'h0000; ew = 1'b0; ep = 3'd6;
      end else begin
        em = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        es = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        mv = (m_ph == 0 || m_ph == 1) ? m_rem : (m_ph == 2) ? 0 : ttg(m_ph, m_rem, 0);
        sv = (m_ph == 3 || m_ph == 4) ? m_rem : (m_ph == 5) ? 0 : ttg(m_ph, m_rem, 3);
        et = {bcd(mv), bcd(sv)};
        ew = (m_ph == 3);
        ep = 3'(m_ph);
      end
      chk("cyc_light_main", 16'(light_main), 16'(em));
      chk("cyc_light_side", 16'(light_side), 16'(es));
      chk("cyc_light_t", light_t, et);
      chk("cyc_ped_walk", 16'(ped_walk), 16'(ew));
      chk("cyc_ped_pending", 16'(ped_pending), 16'(m_pend));
      chk("cyc_phase", 16'(phase), 16'(ep));
    end
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk) tick_1s = 1'b1;
      @(negedge sys_clk) tick_1s = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic press_ped();
    ped_req = 1'b1;
    repeat (3) @(negedge sys_clk);
    ped_req = 1'b0;
  endtask

  initial begin
    #2 sys_rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_light_t", light_t, 16'h0200);
    chk("rst_main", 16'(light_main), 16'h0004);
    chk("rst_side", 16'(light_side), 16'h0004);

    tick_n(2);
    chk("mg_main", 16'(light_main), 16'h0001);
    chk("mg_side", 16'(light_side), 16'h0004);
    chk("mg_light_t", light_t, 16'h3035);

    tick_n(35);
    chk("sg_light_t", light_t, 16'h2520);
    chk("sg_walk", 16'(ped_walk), 16'h0001);
    tick_n(25);
    chk("cycle_back_light_t", light_t, 16'h3035);

    tick_n(10);
    press_ped();
    chk("ped_pending_set", 16'(ped_pending), 16'h0001);
    chk("ped_cut_light_t", light_t, 16'h0510);
    tick_n(10);
    chk("ped_walk_sg", 16'(ped_walk), 16'h0001);
    chk("ped_clear_sg", 16'(ped_pending), 16'h0000);

    tick_n(20);
    chk("sy_light_t", light_t, 16'h0503);
    press_ped();
    chk("sy_pending", 16'(ped_pending), 16'h0001);
    tick_n(5);
    chk("mg_entry_cut", light_t, 16'h0510);
    tick_n(2);
    press_ped();
    chk("late_press_no_cut", light_t, 16'h0308);
    tick_n(4);
    chk("my_light_t", light_t, 16'h0204);

    night_mode = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("night_main_on", 16'(light_main), 16'h0002);
    chk("night_side_on", 16'(light_side), 16'h0002);
    chk("night_light_t", light_t, 16'h0000);
    chk("night_pend_held", 16'(ped_pending), 16'h0001);
    tick_n(1);
    chk("night_main_off", 16'(light_main), 16'h0000);
    tick_n(1);
    chk("night_main_on2", 16'(light_main), 16'h0002);
    night_mode = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("day_light_t", light_t, 16'h0200);
    chk("day_phase", 16'(phase), 16'h0005);
    tick_n(2);
    chk("day_mg_cut", light_t, 16'h0510);
    tick_n(10);
    chk("day_sg_pend", 16'(ped_pending), 16'h0000);

    tick_n(5);
    press_ped();
    chk("pre_rst_pend", 16'(ped_pending), 16'h0001);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("arst_light_t", light_t, 16'h0200);
    chk("arst_main", 16'(light_main), 16'h0004);
    chk("arst_side", 16'(light_side), 16'h0004);
    chk("arst_walk", 16'(ped_walk), 16'h0000);
    chk("arst_pend", 16'(ped_pending), 16'h0000);
    chk("arst_phase", 16'(phase), 16'h0005);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick_n(2);
    chk("post_rst_mg", light_t, 16'h3035);
    repeat (2) @(negedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_2way.md
Name: traffic_light_ctrl_2way

Overview:
Parametrised two-road (main/side) intersection controller, the successor to the single-road traffic light FSM. It advances one phase timer per 1 Hz enable strobe and drives R/Y/G for both roads. It adds a latched pedestrian request that shortens main green, a night mode (flashing yellow), and per-road BCD countdowns packed for the 4-digit display.

Parameters:
T_MAIN_GREEN, 30, main green duration in ticks (1..99)
T_SIDE_GREEN, 20, side green duration in ticks (1..99)
T_YELLOW, 3, yellow duration in ticks, both roads (1..99)
T_ALLRED, 2, all-red clearance in ticks (1..99)
T_PED_CUT, 5, remaining main green after a pedestrian request (1..T_MAIN_GREEN)
CNT_W, 7, phase counter width; constraint: T_x_GREEN+T_YELLOW+T_ALLRED <= 99

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
tick_1s  in  1  one-sys_clk-wide enable strobe, 1 Hz
ped_req  in  1  raw pedestrian button level, asynchronous
night_mode  in  1  raw night-mode switch level, asynchronous
light_main  out  3  main road {R,Y,G}, one-hot except night
light_side  out  3  side road {R,Y,G}
light_t  out  16  BCD {main_tens, main_ones, side_tens, side_ones}
ped_walk  out  1  pedestrian walk lamp
ped_pending  out  1  request latched, not yet served
phase  out  3  current state encoding, debug

Behaviour:
- ped_req, night_mode: 2-FF synchronisers; ped_req rising edge detected after sync.
- States: MAIN_G -> MAIN_Y -> ALL_RED1 -> SIDE_G -> SIDE_Y -> ALL_RED2 -> MAIN_G; plus NIGHT.
- Counter cnt loaded with the phase duration on entry. On tick_1s: cnt==1 -> next state, load its duration; else cnt-1. No tick -> hold.
- All outputs registered; they change the sys_clk after the triggering tick/edge.
- Lights: G-phase road 001, Y-phase road 010, other road 100; both ALL_RED states 100/100.
- light_t, green/yellow road: cnt. Red road shows time-to-green:
  - MAIN_G: side = cnt+T_YELLOW+T_ALLRED.
  - MAIN_Y: side = cnt+T_ALLRED.
  - ALL_RED1: side = cnt, main = 00.
  - SIDE_* states are symmetric.
  - ALL_RED2: main = cnt, side = 00.
  - Binary-to-2-digit BCD conversion is combinational, registered at output.
- Pedestrian:
  - A sync'd rising edge sets ped_pending. A second press while pending has no effect.
  - In MAIN_G, while pending and cnt > T_PED_CUT: cnt := T_PED_CUT, same clock as latch or on MAIN_G entry (entry loads T_PED_CUT instead of T_MAIN_GREEN).
  - ped_pending clears on SIDE_G entry. ped_walk = 1 throughout SIDE_G only.
- Priority in one cycle: night > phase transition (cnt==1 & tick) > ped cut > decrement.
- Night:
  - sync'd night_mode=1 -> NIGHT next clock from any state. flash := 1, toggles each tick.
  - Both roads show {0,flash,0}; light_t=16'h0000; ped_walk=0; ped_pending held.
  - night_mode=0 -> ALL_RED2 with cnt=T_ALLRED, then normal cycle.
- Reset (async, any time): state ALL_RED2, cnt=T_ALLRED, lights 100/100, light_t = {BCD(T_ALLRED),8'h00}, ped_walk=0, ped_pending=0, flash=0, synchronisers cleared.
- Full cycle length without requests: 2*(T_YELLOW+T_ALLRED)+T_MAIN_GREEN+T_SIDE_GREEN ticks.

Decomposition:
- Package traffic_pkg: state enum (MAIN_G, MAIN_Y, ALL_RED1, SIDE_G, SIDE_Y, ALL_RED2, NIGHT), light constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001, LT_OFF=3'b000.
- One sub-module bin2bcd_2d: 7-bit binary (0..99) -> 8-bit BCD, combinational, instantiated twice.

Test Plan (defaults):
- Reset released -> light_t=16'h0200, lights 100/100; after 2 ticks -> MAIN_G, light_main=001, light_side=100, light_t=16'h3035.
- 60 ticks with no requests -> state sequence and durations 30/3/2/20/3/2, back to MAIN_G with light_t=16'h3035; SIDE_G entry shows 16'h2520 inverted fields (main 25, side 20).
- ped_req pulse (3 clocks) at MAIN_G cnt=20 -> ped_pending=1, light_t=16'h0510 two sync clocks later; ped_walk=1 during SIDE_G; ped_pending=0 on SIDE_G entry.
- ped_req during SIDE_Y -> next MAIN_G loads 5, not 30; press at MAIN_G cnt=3 -> cnt unchanged.
- night_mode=1 mid MAIN_Y -> NIGHT, yellows 010 then 000 on alternate ticks, light_t=0; release -> ALL_RED2 with 02, then MAIN_G.
- sys_rst_n low mid SIDE_G with pending request -> immediate reset values, no tick needed.
